// File: rtl/demux1_16_32bit_reg.sv
// Registered 1-to-16 demultiplexer: steers one WIDTH-bit word per clock into one
// of sixteen holding registers, chosen by sel (auto=0) or an auto-increment pointer.
// Latency: 1 cycle. No backpressure; manual writes are always accepted, and auto writes to a full bank are dropped and flagged in erro.
//
// Ports:
//   clock, reset_n     : clock and asynchronous active-low reset
//   sel, dado, escreve : target slot, write data, write strobe
//   auto               : 1 = target is the internal pointer, 0 = target is sel
//   limpa              : synchronous clear of the bank and status (wins over escreve)
//   saida              : flattened slot contents, slot k at [WIDTH*k +: WIDTH]
//   validos            : per-slot written-since-clear bits
//   ponteiro           : current auto-increment pointer
//   cheio, erro        : bank full, sticky rejected-auto-write flag
module demux1_16_32bit_reg #(
  parameter int WIDTH = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [3:0]          sel,
  input  logic [WIDTH-1:0]    dado,
  input  logic                escreve,
  input  logic                auto,
  input  logic                limpa,
  output logic [16*WIDTH-1:0] saida,
  output logic [15:0]         validos,
  output logic [3:0]          ponteiro,
  output logic                cheio,
  output logic                erro
);

  // Occupancy is a pure function of the valid bits, so it can never disagree
  // with them; there is deliberately no separate state register.
  typedef enum logic [1:0] {
    VAZIO   = 2'd0,
    PARCIAL = 2'd1,
    CHEIO   = 2'd2
  } ocupacao_t;

  logic [WIDTH-1:0] r_slot [16];
  logic [15:0]      r_validos;
  logic [3:0]       r_ponteiro;
  logic             r_erro;

  ocupacao_t        w_estado;
  logic             w_cheio;
  logic [3:0]       w_alvo;
  logic             w_aceita;

  always_comb begin
    w_estado = PARCIAL;
    if (r_validos == 16'h0000) begin
      w_estado = VAZIO;
    end else if (r_validos == 16'hFFFF) begin
      w_estado = CHEIO;
    end
  end

  assign w_cheio = (w_estado == CHEIO);

  // The full check uses the pre-edge occupancy: the write that completes the
  // set is accepted and only the following auto write is rejected.
  assign w_alvo   = auto ? r_ponteiro : sel;
  assign w_aceita = escreve && (!auto || !w_cheio);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 16; k++) begin
        r_slot[k] <= '0;
      end
      r_validos  <= '0;
      r_ponteiro <= '0;
      r_erro     <= 1'b0;
    end else if (limpa) begin
      for (int k = 0; k < 16; k++) begin
        r_slot[k] <= '0;
      end
      r_validos  <= '0;
      r_ponteiro <= '0;
      r_erro     <= 1'b0;
    end else if (escreve) begin
      if (w_aceita) begin
        r_slot[w_alvo]    <= dado;
        r_validos[w_alvo] <= 1'b1;
        if (auto) begin
          // 4-bit pointer wraps 15 -> 0 naturally; already-valid slots are not skipped.
          r_ponteiro <= r_ponteiro + 4'd1;
        end
      end else begin
        r_erro <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_saida
    assign saida[WIDTH*g +: WIDTH] = r_slot[g];
  end

  assign validos  = r_validos;
  assign ponteiro = r_ponteiro;
  assign cheio    = w_cheio;
  assign erro     = r_erro;

endmodule

// File: tb/tb_demux1_16_32bit_reg.sv
// Bench for demux1_16_32bit_reg: directed scenarios plus randomized traffic
// checked against an array-based reference model of the slot bank.
module tb_demux1_16_32bit_reg;
  localparam int W = 32;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [3:0]      sel = '0;
  logic [W-1:0]    dado = '0;
  logic            escreve = 1'b0;
  logic            auto = 1'b0;
  logic            limpa = 1'b0;
  logic [16*W-1:0] saida;
  logic [15:0]     validos;
  logic [3:0]      ponteiro;
  logic            cheio;
  logic            erro;

  int n_vec = 0;
  int n_err = 0;

  // Reference model of the bank
  logic [W-1:0] m_slot [16];
  logic [15:0]  m_val;
  int           m_ptr;
  logic         m_erro;

  demux1_16_32bit_reg #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .sel(sel), .dado(dado),
    .escreve(escreve), .auto(auto), .limpa(limpa), .saida(saida),
    .validos(validos), .ponteiro(ponteiro), .cheio(cheio), .erro(erro)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_slot[k] = '0;
    m_val  = '0;
    m_ptr  = 0;
    m_erro = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model at the edge, return at the
  // following falling edge so outputs are sampled away from the active edge.
  task automatic cyc(input logic e, input logic a, input logic l,
                     input logic [3:0] s, input logic [W-1:0] d);
    escreve = e; auto = a; limpa = l; sel = s; dado = d;
    @(posedge clock);
    if (l) begin
      model_reset();
    end else if (e) begin
      if (!a) begin
        m_slot[s] = d;
        m_val[s]  = 1'b1;
      end else if (m_val != 16'hFFFF) begin
        m_slot[m_ptr] = d;
        m_val[m_ptr]  = 1'b1;
        m_ptr = (m_ptr + 1) % 16;
      end else begin
        m_erro = 1'b1;
      end
    end
    @(negedge clock);
    escreve = 1'b0; limpa = 1'b0; auto = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    n_vec++; if (saida !== '0) begin n_err++; $display("FAIL reset_saida got %h want 0", saida); end
    n_vec++; if (validos !== 16'h0) begin n_err++; $display("FAIL reset_validos got %h want 0000", validos); end
    n_vec++; if (ponteiro !== 4'h0) begin n_err++; $display("FAIL reset_ponteiro got %0d want 0", ponteiro); end
    n_vec++; if (cheio !== 1'b0 || erro !== 1'b0) begin n_err++; $display("FAIL reset_status got cheio=%b erro=%b want 0 0", cheio, erro); end
    reset_n = 1'b1;
  endtask

  task automatic test_manual();
    logic [15:0] exp_val;
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 4'(k), 32'hA000_0000 + W'(k));
      exp_val = 16'((17'h1 << (k + 1)) - 17'h1);
      n_vec++; if (validos !== exp_val) begin n_err++; $display("FAIL manual_validos k=%0d got %h want %h", k, validos, exp_val); end
      n_vec++; if (cheio !== (k == 15)) begin n_err++; $display("FAIL manual_cheio k=%0d got %b want %b", k, cheio, (k == 15)); end
      n_vec++; if (ponteiro !== 4'h0) begin n_err++; $display("FAIL manual_ponteiro k=%0d got %0d want 0", k, ponteiro); end
    end
    for (int k = 0; k < 16; k++) begin
      n_vec++; if (saida[k*W +: W] !== 32'hA000_0000 + W'(k)) begin n_err++; $display("FAIL manual_slot%0d got %h want %h", k, saida[k*W +: W], 32'hA000_0000 + W'(k)); end
    end
    cyc(1'b0, 1'b0, 1'b1, 4'h0, '0);
  endtask

  task automatic test_auto_fill();
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 4'h0, W'(k + 1));
      n_vec++; if (ponteiro !== 4'((k + 1) % 16)) begin n_err++; $display("FAIL auto_ponteiro k=%0d got %0d want %0d", k, ponteiro, (k + 1) % 16); end
    end
    for (int k = 0; k < 16; k++) begin
      n_vec++; if (saida[k*W +: W] !== W'(k + 1)) begin n_err++; $display("FAIL auto_slot%0d got %h want %h", k, saida[k*W +: W], k + 1); end
    end
    n_vec++; if (cheio !== 1'b1 || erro !== 1'b0) begin n_err++; $display("FAIL auto_full_status got cheio=%b erro=%b want 1 0", cheio, erro); end
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 32'hDEAD_BEEF);
    n_vec++; if (saida[0 +: W] !== 32'h1) begin n_err++; $display("FAIL auto_reject_slot0 got %h want 00000001", saida[0 +: W]); end
    n_vec++; if (erro !== 1'b1) begin n_err++; $display("FAIL auto_reject_erro got %b want 1", erro); end
    n_vec++; if (ponteiro !== 4'h0) begin n_err++; $display("FAIL auto_reject_ponteiro got %0d want 0", ponteiro); end
  endtask

  task automatic test_manual_full();
    cyc(1'b1, 1'b0, 1'b0, 4'd5, 32'h1234_5678);
    n_vec++; if (saida[5*W +: W] !== 32'h1234_5678) begin n_err++; $display("FAIL full_manual_slot5 got %h want 12345678", saida[5*W +: W]); end
    n_vec++; if (erro !== 1'b1 || cheio !== 1'b1) begin n_err++; $display("FAIL full_manual_status got erro=%b cheio=%b want 1 1", erro, cheio); end
  endtask

  task automatic test_limpa_escreve();
    // Bank is full with erro set: clear with a concurrent write.
    cyc(1'b1, 1'b0, 1'b1, 4'd9, 32'hFFFF_FFFF);
    n_vec++; if (erro !== 1'b0 || validos !== 16'h0 || saida !== '0) begin n_err++; $display("FAIL limpa_full got erro=%b validos=%h want 0 0000", erro, validos); end
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b0, 4'h0, W'(32'h100 + k));
    n_vec++; if (validos !== 16'h000F || ponteiro !== 4'd4) begin n_err++; $display("FAIL limpa_prefill got validos=%h ptr=%0d want 000F 4", validos, ponteiro); end
    cyc(1'b1, 1'b0, 1'b1, 4'd9, 32'hFFFF_FFFF);
    n_vec++; if (saida !== '0) begin n_err++; $display("FAIL limpa_saida slot9=%h want all 0", saida[9*W +: W]); end
    n_vec++; if (validos !== 16'h0 || ponteiro !== 4'h0 || erro !== 1'b0) begin n_err++; $display("FAIL limpa_status got validos=%h ptr=%0d erro=%b want 0000 0 0", validos, ponteiro, erro); end
  endtask

  task automatic test_mixed();
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 32'd5);
    n_vec++; if (ponteiro !== 4'd1) begin n_err++; $display("FAIL mixed_ptr1 got %0d want 1", ponteiro); end
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 32'd7);
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 32'd9);
    n_vec++; if (saida[0 +: W] !== 32'd7 || saida[W +: W] !== 32'd9) begin n_err++; $display("FAIL mixed_slots got %h %h want 7 9", saida[0 +: W], saida[W +: W]); end
    n_vec++; if (ponteiro !== 4'd2 || validos !== 16'h0003) begin n_err++; $display("FAIL mixed_status got ptr=%0d validos=%h want 2 0003", ponteiro, validos); end
    cyc(1'b0, 1'b0, 1'b1, 4'h0, '0);
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b0, 4'h0, W'(32'h50 + k));
    escreve = 1'b1; auto = 1'b1; dado = 32'h0BAD_0001;
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (saida !== '0 || validos !== 16'h0 || ponteiro !== 4'h0 || cheio !== 1'b0 || erro !== 1'b0) begin
      n_err++; $display("FAIL async_reset got validos=%h ptr=%0d cheio=%b erro=%b want all 0", validos, ponteiro, cheio, erro);
    end
    model_reset();
    #1 reset_n = 1'b1;
    @(posedge clock);
    m_slot[0] = 32'h0BAD_0001; m_val[0] = 1'b1; m_ptr = 1;
    @(negedge clock);
    escreve = 1'b0; auto = 1'b0;
    n_vec++; if (saida[0 +: W] !== 32'h0BAD_0001 || ponteiro !== 4'd1 || validos !== 16'h0001) begin
      n_err++; $display("FAIL async_first_write got slot0=%h ptr=%0d validos=%h want 0bad0001 1 0001", saida[0 +: W], ponteiro, validos);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      cyc(($urandom_range(3) != 0), $urandom_range(1) == 1, ($urandom_range(39) == 0),
          4'($urandom_range(15)), W'($urandom));
      for (int k = 0; k < 16; k++) begin
        n_vec++; if (saida[k*W +: W] !== m_slot[k]) begin n_err++; $display("FAIL rand_slot%0d cyc=%0d got %h want %h", k, c, saida[k*W +: W], m_slot[k]); end
      end
      n_vec++; if (validos !== m_val) begin n_err++; $display("FAIL rand_validos cyc=%0d got %h want %h", c, validos, m_val); end
      n_vec++; if (ponteiro !== 4'(m_ptr)) begin n_err++; $display("FAIL rand_ponteiro cyc=%0d got %0d want %0d", c, ponteiro, m_ptr); end
      n_vec++; if (cheio !== (m_val == 16'hFFFF)) begin n_err++; $display("FAIL rand_cheio cyc=%0d got %b want %b", c, cheio, (m_val == 16'hFFFF)); end
      n_vec++; if (erro !== m_erro) begin n_err++; $display("FAIL rand_erro cyc=%0d got %b want %b", c, erro, m_erro); end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_auto_fill();
    test_manual_full();
    test_limpa_escreve();
    test_mixed();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
